// File: rtl/mux_panel_pkg.sv
// Shared definitions for the button/LED exerciser panels: select-width helper
// and default debounce/PWM constants.
package panel_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int PWM_W_DEF      = 8;
  localparam int DUTY_DEF       = 8;

  // Width of a binary channel index; a single channel pair still needs one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_panel_if.sv
// Button inputs and dimmed LED outputs of a mux panel.
interface mux_panel_if
  import panel_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int SEL_W = sel_w(N_CH)
);

  logic [N_CH-1:0]  data_btn;
  logic             sel_btn;
  logic             led_mux;
  logic [N_CH-1:0]  led_dmux;
  logic [SEL_W-1:0] led_sel;

  modport master (
    output data_btn, sel_btn,
    input  led_mux, led_dmux, led_sel
  );

  modport slave (
    input  data_btn, sel_btn,
    output led_mux, led_dmux, led_sel
  );

endinterface

// File: rtl/mux_panel_debounce.sv
// Single-button debouncer: 2-flop synchroniser followed by a stability counter
// that flips the output after DEB_CYCLES consecutive mismatching edges.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic deb_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync2_q;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/mux_panel.sv
// Debounced N-channel mux/demux exerciser: a select button steps the channel
// index and all LED outputs are registered and PWM-dimmed.
module mux_panel
  import panel_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int PWM_W      = PWM_W_DEF,
  parameter int DUTY       = DUTY_DEF
) (
  input logic       clk,
  input logic       rst_n,
  mux_panel_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);
  localparam logic [PWM_W:0]   DUTY_C   = (PWM_W + 1)'(DUTY);

  logic [N_CH:0]   raw, deb;
  logic [N_CH-1:0] data_deb;
  logic            sel_deb;

  assign raw = {bus.sel_btn, bus.data_btn};

  for (genvar g = 0; g <= N_CH; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (raw[g]),
      .deb_o (deb[g])
    );
  end

  assign data_deb = deb[N_CH-1:0];
  assign sel_deb  = deb[N_CH];

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             deb_sel_q;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             led_mux_q;
  logic [N_CH-1:0]  led_dmux_q;
  logic [SEL_W-1:0] led_sel_q;

  logic [N_CH-1:0]  sel_oh;
  logic             mux_val;
  logic [N_CH-1:0]  dmux_val;
  logic             pwm_on;

  always_comb begin
    sel_d = sel_q;
    if (sel_deb && !deb_sel_q)
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // Outputs use the pre-update select, so a new index shows one cycle later.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_CH; i++) sel_oh[i] = (sel_q == SEL_W'(i));
  end

  assign mux_val  = |(data_deb & sel_oh);
  assign dmux_val = sel_oh & {N_CH{mux_val}};
  assign pwm_on   = ({1'b0, pwm_cnt_q} < DUTY_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      deb_sel_q  <= 1'b0;
      pwm_cnt_q  <= '0;
      led_mux_q  <= 1'b0;
      led_dmux_q <= '0;
      led_sel_q  <= '0;
    end else begin
      sel_q      <= sel_d;
      deb_sel_q  <= sel_deb;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      led_mux_q  <= pwm_on & mux_val;
      led_dmux_q <= pwm_on ? dmux_val : '0;
      led_sel_q  <= pwm_on ? sel_q : '0;
    end
  end

  assign bus.led_mux  = led_mux_q;
  assign bus.led_dmux = led_dmux_q;
  assign bus.led_sel  = led_sel_q;

endmodule

// File: doc/mux_panel.md
# mux_panel

Parametrised button-to-LED exerciser for the combinational gate library. It debounces N_CH data buttons and one select button. The select button steps a registered channel index with wrap-around. The block drives a mux result LED, an N_CH-wide demux LED bank and a binary select indicator, all PWM-dimmed. It sits directly under `top` on the board build and replaces the fixed 2:1 mux/dmux demo with a sized, debounced, stateful one.

## Interface
- N_CH, 3: data channels; ≥ 2, need not be a power of two
- DEB_CYCLES, 4: consecutive stable cycles required to accept a button change; ≥ 1
- PWM_W, 8: PWM counter width
- DUTY, 8: on-cycles per 2^PWM_W period; 0 ≤ DUTY ≤ 2^PWM_W; 0 = always off, 2^PWM_W = always on
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- DATA_BTN  in  N_CH  raw data buttons, active-high, asynchronous to CLK
- SEL_BTN  in  1  raw select button, active-high, asynchronous
- LED_MUX  out  1  dimmed data[sel]
- LED_DMUX  out  N_CH  dimmed demux: bit i = (i == sel) & data[sel]
- LED_SEL  out  SEL_W  dimmed binary sel; SEL_W = max(1, clog2(N_CH))

## Operation
- Every button (N_CH + 1) passes through an independent `btn_debounce`:
  - 2-flop synchroniser, then a counter of width clog2(DEB_CYCLES+1).
  - Counter increments on each edge where the synced value ≠ the debounced value.
  - Counter clears on any edge where they match, so a bounce restarts the count.
  - When the counter reaches DEB_CYCLES-1 with the mismatch still present, the debounced value flips and the counter clears.
- Select: register `deb_sel_d` holds the previous debounced SEL. On a rising edge (deb & ~deb_d), sel ← (sel == N_CH-1) ? 0 : sel+1. There is no other sel update. A press held indefinitely counts once.
- PWM: free-running PWM_W-bit counter, wraps 2^PWM_W-1 → 0. `pwm_on` = (cnt < DUTY), compared at PWM_W+1 bits.
- Outputs are registered each edge as `pwm_on & value`. The value is computed from the current (pre-update) sel and debounced data.
- Reset (RST_N low, asynchronous) clears all of the following to 0: sync flops, debounce counters and values, deb_sel_d, sel, PWM counter, and every output.
- Reset mid-operation returns the block to this state immediately.

## Timing
- Edge numbering: edge 0 is the first CLK edge after a raw input change.
- Sync stage 2 is valid after edge 1. The debounced value flips at edge DEB_CYCLES+1. LED outputs reflect the new data at edge DEB_CYCLES+2 (DUTY full).
- A SEL press updates sel at edge DEB_CYCLES+2. LED_SEL, LED_MUX and LED_DMUX reflect the new sel at edge DEB_CYCLES+3.
- A data change and a sel change in the same edge: outputs use the old sel for one cycle, then the new sel.
- A button held through reset release debounces from 0. A held SEL therefore counts as one press: sel = 1 at edge DEB_CYCLES+2 after release.
- Bounce shorter than DEB_CYCLES cycles produces no output change.
- PWM on-window is cycles 0..DUTY-1 of each 2^PWM_W period, counted from reset release.

## Structure
- `panel_pkg` holds the SEL_W width function (max(1, clog2(n))) and the default DEB_CYCLES/PWM_W/DUTY constants shared with future panels.
- One sub-module, `btn_debounce` (parameter DEB_CYCLES; ports CLK, RST_N, raw, deb). It is instantiated N_CH+1 times via generate.
- The mux/demux and PWM comparison are inline in `mux_panel`.

## Test plan
Params unless stated otherwise: N_CH=3, DEB_CYCLES=4, PWM_W=3, DUTY=8.
- Reset: RST_N low mid-clock → all outputs 0 without waiting for an edge. Release, hold all buttons 0 for 20 cycles → outputs stay 0.
- Clean data press: DATA_BTN=3'b001, held → LED_MUX=1 and LED_DMUX=3'b001 at edge 6, not before. Release → both 0 at edge 6 after release.
- Bounce: DATA_BTN[0] toggles every 2 cycles for 20 cycles, then held 0 → LED_MUX never asserts.
- Select wrap: DATA_BTN=3'b100. Three clean SEL presses → LED_SEL 1, 2, 0. After press 2: LED_MUX=1, LED_DMUX=3'b100. After press 3: LED_MUX=0, LED_DMUX=0. A 50-cycle hold counts once.
- PWM: DUTY=2, DATA_BTN=3'b001 held → LED_MUX high exactly 2 of every 8 cycles, in cycles 0–1 of the period. DUTY=0 → never high.
- Reset mid-op: with sel=2, pulse RST_N low → LED_SEL=0 immediately. Release with SEL_BTN held → LED_SEL=1 at edge 7.
